// File: rtl/sm4_pkg.sv
// Shared constants and types for the SM4 host-side feeder.
//   WORD_WIDTH   : master key word width
//   IO_WIDTH     : serial beat width toward the core
//   BLOCK_LENGTH : SM4 block width
//   BEATS        : beats per block, BEAT_W its index width (minimum 1)
//   StIdle/StCfg/StStream : feeder FSM encoding
package sm4_pkg;

  localparam int unsigned WORD_WIDTH   = 32;
  localparam int unsigned IO_WIDTH     = 32;
  localparam int unsigned BLOCK_LENGTH = 128;
  localparam int unsigned BEATS        = BLOCK_LENGTH / IO_WIDTH;
  localparam int unsigned BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ENTRY_W      = BLOCK_LENGTH + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCfg    = 2'd1;
  localparam logic [1:0] StStream = 2'd2;

  typedef struct packed {
    logic                    last;
    logic [BLOCK_LENGTH-1:0] data;
  } fifo_entry_t;

  // Beat idx of a block, MSB-first: shift the wanted slice to the top.
  function automatic logic [IO_WIDTH-1:0] beat_slice(input logic [BLOCK_LENGTH-1:0] blk,
                                                      input logic [BEAT_W-1:0]       idx);
    logic [BLOCK_LENGTH-1:0] sh;
    sh = blk << (int'(idx) * IO_WIDTH);
    return sh[BLOCK_LENGTH-1 -: IO_WIDTH];
  endfunction

endpackage

// File: rtl/sm4_blk_fifo.sv
// Synchronous block FIFO for the SM4 feeder.
//   clk_i/rst_i      : clock, synchronous active-high reset
//   wr_en_i/wr_data_i: push (ignored when full)
//   rd_en_i          : pop (ignored when empty); rd_data_o shows the head entry
//   empty_o/full_o   : registered flags, full_next_o is full as of the next edge
module sm4_blk_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 129
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             full_next_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_go, rd_go;

  assign wr_go = wr_en_i && !full_o;
  assign rd_go = rd_en_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (wr_go && !rd_go) begin
      count_d = count_q + CntW'(1);
    end else if (rd_go && !wr_go) begin
      count_d = count_q - CntW'(1);
    end
  end

  assign full_next_o = (count_d == CntW'(Depth));
  assign rd_data_o   = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_o  <= 1'b1;
      full_o   <= 1'b0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (wr_go) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_go) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      empty_o <= (count_d == '0);
      full_o  <= full_next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_go) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/sm4_feeder.sv
// Host-side feeder for the SM4 core.
//   key_req/key_mod/key_mk -> key_ack, cfg pulse, cfg_mod, cfg_mk0..3 (mk0 = key_mk MSBs)
//   blk_valid/blk_ready/blk_data/blk_last : block push into a FIFO_DEPTH-entry buffer
//   hold_i -> val_i/eop_i/dat_i : MSB-first serialisation of buffered blocks
//   err -> err_flag (sticky, cleared by key_ack), done -> done_cnt (wrapping)
// All outputs are registered; reset is synchronous active-high.
module sm4_feeder
  import sm4_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_req,
  input  logic                    key_mod,
  input  logic [4*WORD_WIDTH-1:0] key_mk,
  output logic                    key_ack,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [BLOCK_LENGTH-1:0] blk_data,
  input  logic                    blk_last,
  output logic                    cfg,
  output logic                    cfg_mod,
  output logic [WORD_WIDTH-1:0]   cfg_mk0,
  output logic [WORD_WIDTH-1:0]   cfg_mk1,
  output logic [WORD_WIDTH-1:0]   cfg_mk2,
  output logic [WORD_WIDTH-1:0]   cfg_mk3,
  input  logic                    hold_i,
  output logic                    val_i,
  output logic                    eop_i,
  output logic [IO_WIDTH-1:0]     dat_i,
  input  logic                    err,
  input  logic                    done,
  output logic                    err_flag,
  output logic [CNT_WIDTH-1:0]    done_cnt
);

  logic [1:0]              state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    key_ack_q, key_ack_d;
  logic                    cfg_q;
  logic                    cfg_mod_q, cfg_mod_d;
  logic [4*WORD_WIDTH-1:0] cfg_mk_q, cfg_mk_d;
  logic                    val_q, val_d;
  logic                    eop_q, eop_d;
  logic [IO_WIDTH-1:0]     dat_q, dat_d;
  logic                    err_flag_q;
  logic [CNT_WIDTH-1:0]    done_cnt_q;
  logic                    blk_ready_q;

  fifo_entry_t head;
  logic        fifo_pop, fifo_empty, fifo_full, fifo_full_next;

  sm4_blk_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (ENTRY_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (blk_valid && blk_ready_q),
    .wr_data_i   ({blk_last, blk_data}),
    .rd_en_i     (fifo_pop),
    .rd_data_o   (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .full_next_o (fifo_full_next)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    key_ack_d = 1'b0;
    cfg_mod_d = cfg_mod_q;
    cfg_mk_d  = cfg_mk_q;
    val_d     = 1'b0;
    eop_d     = 1'b0;
    dat_d     = dat_q;
    fifo_pop  = 1'b0;
    case (state_q)
      StIdle: begin
        // Key loads win over pending blocks, but only between packets.
        if (key_req) begin
          cfg_mk_d  = key_mk;
          cfg_mod_d = key_mod;
          key_ack_d = 1'b1;
          state_d   = StCfg;
        end else if (!fifo_empty) begin
          state_d = StStream;
        end
      end
      StCfg: state_d = StIdle;
      StStream: begin
        // An empty FIFO mid-packet just idles the bus until the next entry.
        if (!hold_i && !fifo_empty) begin
          val_d = 1'b1;
          dat_d = beat_slice(head.data, beat_q);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            eop_d    = head.last;
            fifo_pop = 1'b1;
            beat_d   = '0;
            if (head.last) state_d = StIdle;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      key_ack_q   <= 1'b0;
      cfg_q       <= 1'b0;
      cfg_mod_q   <= 1'b0;
      cfg_mk_q    <= '0;
      val_q       <= 1'b0;
      eop_q       <= 1'b0;
      dat_q       <= '0;
      err_flag_q  <= 1'b0;
      done_cnt_q  <= '0;
      blk_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      key_ack_q   <= key_ack_d;
      cfg_q       <= (state_q == StCfg);
      cfg_mod_q   <= cfg_mod_d;
      cfg_mk_q    <= cfg_mk_d;
      val_q       <= val_d;
      eop_q       <= eop_d;
      dat_q       <= dat_d;
      // A new error in the key_ack cycle must not be lost to the clear.
      err_flag_q  <= err || (err_flag_q && !key_ack_q);
      done_cnt_q  <= done_cnt_q + CNT_WIDTH'(done);
      blk_ready_q <= !fifo_full_next;
    end
  end

  assign key_ack   = key_ack_q;
  assign blk_ready = blk_ready_q;
  assign cfg       = cfg_q;
  assign cfg_mod   = cfg_mod_q;
  assign cfg_mk0   = cfg_mk_q[4*WORD_WIDTH-1 -: WORD_WIDTH];
  assign cfg_mk1   = cfg_mk_q[3*WORD_WIDTH-1 -: WORD_WIDTH];
  assign cfg_mk2   = cfg_mk_q[2*WORD_WIDTH-1 -: WORD_WIDTH];
  assign cfg_mk3   = cfg_mk_q[WORD_WIDTH-1 -: WORD_WIDTH];
  assign val_i     = val_q;
  assign eop_i     = eop_q;
  assign dat_i     = dat_q;
  assign err_flag  = err_flag_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_sm4_feeder.sv
// Self-checking bench for sm4_feeder: randomized blocks and keys compared against
// a beat-level reference queue built directly from the block contents.
module tb_sm4_feeder;

  localparam int BL  = 128;
  localparam int IOW = 32;
  localparam int NB  = BL / IOW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_req = 1'b0, key_mod = 1'b0;
  logic [127:0]  key_mk = '0;
  logic          key_ack;
  logic          blk_valid = 1'b0, blk_ready;
  logic [BL-1:0] blk_data = '0;
  logic          blk_last = 1'b0;
  logic          cfg, cfg_mod;
  logic [31:0]   cfg_mk0, cfg_mk1, cfg_mk2, cfg_mk3;
  logic          hold_i = 1'b0, val_i, eop_i;
  logic [IOW-1:0] dat_i;
  logic          err = 1'b0, done = 1'b0, err_flag;
  logic [15:0]   done_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int overlap = 0;
  int done_model = 0;

  logic [IOW-1:0] got_dat[$], exp_dat[$];
  logic           got_eop[$], exp_eop[$];
  int             got_cyc[$];

  sm4_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .key_req   (key_req),
    .key_mod   (key_mod),
    .key_mk    (key_mk),
    .key_ack   (key_ack),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .cfg       (cfg),
    .cfg_mod   (cfg_mod),
    .cfg_mk0   (cfg_mk0),
    .cfg_mk1   (cfg_mk1),
    .cfg_mk2   (cfg_mk2),
    .cfg_mk3   (cfg_mk3),
    .hold_i    (hold_i),
    .val_i     (val_i),
    .eop_i     (eop_i),
    .dat_i     (dat_i),
    .err       (err),
    .done      (done),
    .err_flag  (err_flag),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat monitor and cfg/beat overlap watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (val_i === 1'b1) begin
      got_dat.push_back(dat_i);
      got_eop.push_back(eop_i);
      got_cyc.push_back(cyc);
    end
    if (cfg === 1'b1 && val_i === 1'b1) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: a block becomes NB beats, top slice first, eop on the final beat of a last block.
  function automatic void model_push(input logic [BL-1:0] d, input logic l);
    logic [BL-1:0] t;
    for (int k = 0; k < NB; k++) begin
      t = d << (k * IOW);
      exp_dat.push_back(t[BL-1 -: IOW]);
      exp_eop.push_back(l && (k == NB - 1));
    end
  endfunction

  function automatic void clear_q();
    got_dat.delete(); got_eop.delete(); got_cyc.delete();
    exp_dat.delete(); exp_eop.delete();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [BL-1:0] d, input logic l, input string tag);
    int  k;
    bit  rdy;
    k = 0;
    blk_data = d; blk_last = l; blk_valid = 1'b1;
    do begin
      rdy = blk_ready;
      tick();
      k++;
    end while (!rdy && k < 200);
    blk_valid = 1'b0;
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL %s push_timeout blk_ready=%b required 1", tag, blk_ready);
    end else begin
      model_push(d, l);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (got_dat.size() < exp_dat.size() && k < 400) begin
      tick();
      k++;
    end
    repeat (6) tick();
  endtask

  task automatic key_load(input logic [127:0] mk, input logic md, input bit err_in_ack,
                          input string tag);
    int k;
    k = 0;
    key_mk = mk; key_mod = md; key_req = 1'b1;
    do begin
      tick();
      k++;
    end while (key_ack !== 1'b1 && k < 200);
    ack_cyc = cyc;
    checks++;
    if (key_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s ack_timeout key_ack=%b required 1", tag, key_ack);
      key_req = 1'b0;
    end else begin
      checks++;
      if ({cfg, cfg_mod, cfg_mk0, cfg_mk1, cfg_mk2, cfg_mk3} !== {1'b0, md, mk}) begin
        errors++;
        $display("FAIL %s key_regs cfg=%b mod=%b mk=%h%h%h%h required cfg=0 mod=%b mk=%h",
                 tag, cfg, cfg_mod, cfg_mk0, cfg_mk1, cfg_mk2, cfg_mk3, md, mk);
      end
      key_req = 1'b0;
      err = err_in_ack;
      tick();
      err = 1'b0;
      checks++;
      if ({cfg, key_ack} !== 2'b10) begin
        errors++;
        $display("FAIL %s cfg_pulse cfg=%b key_ack=%b required cfg=1 key_ack=0",
                 tag, cfg, key_ack);
      end
      tick();
      checks++;
      if (cfg !== 1'b0) begin
        errors++;
        $display("FAIL %s cfg_width cfg=%b required 0", tag, cfg);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({key_ack, blk_ready, cfg, cfg_mod, cfg_mk0, cfg_mk1, cfg_mk2, cfg_mk3, val_i, eop_i,
         dat_i, err_flag, done_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b rdy=%b cfg=%b val=%b dat=%h flag=%b cnt=%0d required 0",
               key_ack, blk_ready, cfg, val_i, dat_i, err_flag, done_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({blk_ready, val_i} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release blk_ready=%b val_i=%b required 1 0", blk_ready, val_i);
    end
  endtask

  task automatic test_key_load();
    key_load(128'h0123456789ABCDEFFEDCBA9876543210, 1'b0, 1'b0, "key_load");
    checks++;
    if (cfg_mk0 !== 32'h01234567 || cfg_mk3 !== 32'h76543210) begin
      errors++;
      $display("FAIL key_words mk0=%h mk3=%h required 01234567 76543210", cfg_mk0, cfg_mk3);
    end
  endtask

  task automatic test_single_block();
    int idle_val;
    clear_q();
    push(128'h0123456789ABCDEFFEDCBA9876543210, 1'b1, "single");
    wait_drain();
    checks++;
    if (got_dat.size() !== 4) begin
      errors++;
      $display("FAIL single_len got %0d beats required 4", got_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
      checks++;
      if ({got_eop[i], got_dat[i]} !== {exp_eop[i], exp_dat[i]}) begin
        errors++;
        $display("FAIL single_beat%0d got eop=%b %h required eop=%b %h",
                 i, got_eop[i], got_dat[i], exp_eop[i], exp_dat[i]);
      end
    end
    if (got_cyc.size() >= 4) begin
      checks++;
      if (got_cyc[3] - got_cyc[0] !== 3) begin
        errors++;
        $display("FAIL single_consecutive span %0d cycles required 3", got_cyc[3] - got_cyc[0]);
      end
    end
    idle_val = 0;
    repeat (5) begin tick(); if (val_i !== 1'b0) idle_val++; end
    checks++;
    if (idle_val !== 0) begin
      errors++;
      $display("FAIL single_idle val_i high %0d cycles required 0", idle_val);
    end
  endtask

  task automatic test_back_pressure();
    int n, k, extra;
    clear_q();
    push(rnd128(), 1'b1, "bp");
    n = 0; k = 0;
    while (n < 2 && k < 50) begin
      if (val_i === 1'b1) n++;
      if (n < 2) tick();
      k++;
    end
    checks++;
    if (n < 2) begin
      errors++;
      $display("FAIL bp_start saw %0d beats required 2", n);
    end
    hold_i = 1'b1;
    extra = 0;
    repeat (3) begin tick(); if (val_i === 1'b1) extra++; end
    hold_i = 1'b0;
    tick();
    checks++;
    if (extra > 1) begin
      errors++;
      $display("FAIL bp_extra %0d beats under hold required at most 1", extra);
    end
    checks++;
    if (val_i !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume val_i=%b one cycle after hold fell required 1", val_i);
    end
    wait_drain();
    checks++;
    if (got_dat.size() !== exp_dat.size()) begin
      errors++;
      $display("FAIL bp_len got %0d beats required %0d", got_dat.size(), exp_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
      checks++;
      if ({got_eop[i], got_dat[i]} !== {exp_eop[i], exp_dat[i]}) begin
        errors++;
        $display("FAIL bp_beat%0d got eop=%b %h required eop=%b %h",
                 i, got_eop[i], got_dat[i], exp_eop[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [BL-1:0] d5;
    int ready_seen;
    clear_q();
    hold_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      push(rnd128(), 1'($urandom_range(0, 1)), "full");
      checks++;
      if (blk_ready !== (b < 3)) begin
        errors++;
        $display("FAIL full_ready after accept %0d blk_ready=%b required %b",
                 b + 1, blk_ready, b < 3);
      end
    end
    d5 = rnd128();
    blk_data = d5; blk_last = 1'b1; blk_valid = 1'b1;
    ready_seen = 0;
    repeat (5) begin tick(); if (blk_ready !== 1'b0) ready_seen++; end
    checks++;
    if (ready_seen !== 0) begin
      errors++;
      $display("FAIL full_block blk_ready high %0d cycles while full required 0", ready_seen);
    end
    hold_i = 1'b0;
    push(d5, 1'b1, "full5");
    wait_drain();
    checks++;
    if (got_dat.size() !== 20) begin
      errors++;
      $display("FAIL full_len got %0d beats required 20", got_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
      checks++;
      if ({got_eop[i], got_dat[i]} !== {exp_eop[i], exp_dat[i]}) begin
        errors++;
        $display("FAIL full_beat%0d got eop=%b %h required eop=%b %h",
                 i, got_eop[i], got_dat[i], exp_eop[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_key_during_packet();
    logic [127:0] mk;
    int eop_cyc;
    clear_q();
    overlap = 0;
    mk = rnd128();
    push(rnd128(), 1'b0, "kdp");
    push(rnd128(), 1'b1, "kdp");
    key_load(mk, 1'b1, 1'b0, "kdp_key");
    wait_drain();
    checks++;
    if (got_dat.size() !== 8) begin
      errors++;
      $display("FAIL kdp_len got %0d beats required 8", got_dat.size());
    end
    for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
      checks++;
      if ({got_eop[i], got_dat[i]} !== {exp_eop[i], exp_dat[i]}) begin
        errors++;
        $display("FAIL kdp_beat%0d got eop=%b %h required eop=%b %h",
                 i, got_eop[i], got_dat[i], exp_eop[i], exp_dat[i]);
      end
    end
    eop_cyc = (got_cyc.size() > 0) ? got_cyc[got_cyc.size() - 1] : 0;
    checks++;
    if (ack_cyc <= eop_cyc) begin
      errors++;
      $display("FAIL kdp_ack_order key_ack cycle %0d required after eop cycle %0d",
               ack_cyc, eop_cyc);
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL kdp_overlap %0d beats during cfg required 0", overlap);
    end
  endtask

  task automatic test_err_done_reset();
    int k, stray;
    err = 1'b1; tick(); err = 1'b0;
    repeat (3) begin
      done = 1'b1; tick(); done = 1'b0;
      done_model++;
      repeat ($urandom_range(0, 2)) tick();
    end
    checks++;
    if (err_flag !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky err_flag=%b required 1", err_flag);
    end
    checks++;
    if (done_cnt !== 16'(done_model)) begin
      errors++;
      $display("FAIL done_count done_cnt=%0d required %0d", done_cnt, done_model);
    end
    key_load(rnd128(), 1'b0, 1'b1, "err_set_wins");
    checks++;
    if (err_flag !== 1'b1) begin
      errors++;
      $display("FAIL err_set_wins err_flag=%b required 1", err_flag);
    end
    key_load(rnd128(), 1'b1, 1'b0, "err_clear");
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL err_clear err_flag=%b required 0", err_flag);
    end
    push(rnd128(), 1'b0, "rst_mid");
    k = 0;
    while (val_i !== 1'b1 && k < 50) begin tick(); k++; end
    rst = 1'b1;
    tick();
    checks++;
    if ({key_ack, blk_ready, cfg, cfg_mod, cfg_mk0, cfg_mk1, cfg_mk2, cfg_mk3, val_i, eop_i,
         dat_i, err_flag, done_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs rdy=%b mod=%b val=%b dat=%h cnt=%0d required 0",
               blk_ready, cfg_mod, val_i, dat_i, done_cnt);
    end
    tick();
    rst = 1'b0;
    done_model = 0;
    stray = 0;
    repeat (10) begin tick(); if (val_i !== 1'b0) stray++; end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL midreset_discard val_i high %0d cycles required 0", stray);
    end
    checks++;
    if ({blk_ready, err_flag, done_cnt} !== {1'b1, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL midreset_state rdy=%b flag=%b cnt=%0d required 1 0 0",
               blk_ready, err_flag, done_cnt);
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_single_block();
    test_back_pressure();
    test_fifo_full();
    test_key_during_packet();
    test_err_done_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm4_feeder.md
Name: sm4_feeder

Overview:
Upstream stage of the SM4 core. It accepts 128-bit plaintext/ciphertext blocks and key-load requests from the host side, and issues the one-cycle cfg pulse with mode and master key. It buffers blocks in a small FIFO and serialises each block into IO_WIDTH beats on val_i/eop_i/dat_i, honouring the core's hold_i back-pressure. It also keeps a sticky error flag from err and counts done pulses.

Parameters:
WORD_WIDTH, 32, key word width
IO_WIDTH, 32, serial beat width; must divide BLOCK_LENGTH
BLOCK_LENGTH, 128, SM4 block width
FIFO_DEPTH, 4, block buffer entries; power of 2, at least 2
CNT_WIDTH, 16, done counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
key_req  in  1  host key/mode load request; held until key_ack
key_mod  in  1  0 = encrypt, 1 = decrypt
key_mk  in  4*WORD_WIDTH  master key; mk0 in the MSBs
key_ack  out  1  one-cycle acceptance of key_req
blk_valid  in  1  host block valid
blk_ready  out  1  FIFO not full
blk_data  in  BLOCK_LENGTH  block; serialised MSB-first
blk_last  in  1  block ends a packet
cfg  out  1  one-cycle configuration pulse to the core
cfg_mod  out  1  registered mode, stable between cfg pulses
cfg_mk0..cfg_mk3  out  WORD_WIDTH each  registered master key words
hold_i  in  1  core back-pressure
val_i  out  1  beat valid to the core
eop_i  out  1  last beat of the packet
dat_i  out  IO_WIDTH  beat data
err  in  1  core error
done  in  1  core packet-complete pulse
err_flag  out  1  sticky error
done_cnt  out  CNT_WIDTH  packets completed, wraps

Behaviour:
- Reset values: all outputs 0 (key_ack, blk_ready, cfg, cfg_mod, cfg_mk*, val_i, eop_i, dat_i, err_flag, done_cnt). State is IDLE, FIFO is empty, beat index is 0.
- Reset asserted mid-operation: FIFO contents and any partial block are discarded. Held key/mode registers return to 0.
- BEATS = BLOCK_LENGTH/IO_WIDTH.
  - Beat k carries blk_data[BLOCK_LENGTH-1-k*IO_WIDTH -: IO_WIDTH].
  - The beat index counter is log2(BEATS) bits wide, minimum 1.
- FIFO entry = {blk_last, blk_data}.
  - Write on blk_valid && blk_ready.
  - blk_ready = !full, registered from the next-state count.
  - A simultaneous read and write when full is not allowed, because blk_ready is already 0.
  - A simultaneous read and write when empty cannot occur, because the read requires non-empty.
- FSM states: IDLE, CFG, STREAM.
  - IDLE: if key_req, latch key_mk/key_mod into cfg_mk*/cfg_mod, pulse key_ack, go to CFG. Otherwise, if the FIFO is non-empty, go to STREAM.
  - CFG: cfg=1 for exactly this cycle, then go to IDLE. key_req has priority over pending blocks only in IDLE.
  - STREAM: on each clock edge where hold_i==0 and a beat is available, register val_i=1, dat_i=beat, and eop_i=(last beat && entry.last). Otherwise register val_i=0 and eop_i=0; dat_i holds its previous value.
  - STREAM, block boundary: after the last beat of a block, pop the FIFO. If entry.last, go to IDLE. Otherwise continue with the next entry. If the FIFO is empty mid-packet, stay in STREAM with val_i=0.
- Key/mode changes happen only between packets. key_req arriving during STREAM waits, with key_ack=0, until IDLE.
- hold_i latency: hold_i is sampled at the edge. The core sees at most one further beat after it raises hold_i. When hold_i falls, the next beat appears one cycle later. The beat index does not advance while hold_i=1.
- err_flag: set on any cycle with err=1. Cleared only by reset or by key_ack. If err and key_ack occur in the same cycle, set wins.
- done_cnt: +1 per cycle with done=1, modulo 2^CNT_WIDTH.

Decomposition:
- Package sm4_pkg: WORD_WIDTH, IO_WIDTH, BLOCK_LENGTH, derived BEATS, the FSM state encoding localparams, and the fifo_entry width BLOCK_LENGTH+1.
- One sub-module, sm4_blk_fifo: a synchronous FIFO with full/empty flags and a registered count, FIFO_DEPTH entries of BLOCK_LENGTH+1 bits.
- The FSM, serialiser and counters stay in sm4_feeder.

Test Plan:
1. Key load: key_req with key_mod=0 and key_mk=0x0123456789ABCDEFFEDCBA9876543210 -> key_ack one cycle, cfg high exactly the next cycle, cfg_mk0=0x01234567, cfg_mk3=0x76543210, cfg_mod=0.
2. Single block, blk_last=1, data 0x0123456789ABCDEFFEDCBA9876543210, hold_i=0 -> 4 consecutive val_i beats 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210, with eop_i only on beat 4; FSM returns to IDLE.
3. Back-pressure: hold_i=1 for 3 cycles starting after beat 2 -> at most 1 extra beat, beat order intact, and beats 3–4 resume one cycle after hold_i falls.
4. FIFO full: push 5 blocks back-to-back with hold_i=1 -> blk_ready drops after the 4th accept; after release, all 4 blocks are emitted in order (16 beats), then the 5th is accepted.
5. key_req during a 2-block packet -> key_ack is withheld until after the eop_i beat, then key_ack and cfg follow, and no beat overlaps the cfg cycle.
6. err pulse, then 3 done pulses, then reset mid-block -> err_flag=1 stays set until the next key_ack, done_cnt=3, and after reset all outputs are 0 and val_i stays low with the FIFO empty.
